// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine: register map offsets, address
// region codes, CTRL field positions and the default transparent colour.
package sprite_pkg;

    // address_i[9:8] region codes
    localparam logic [1:0] REGION_SPRITE = 2'b00;
    localparam logic [1:0] REGION_STATUS = 2'b01;

    // address_i[1:0] register offsets inside a sprite channel
    localparam logic [1:0] REG_X    = 2'd0;
    localparam logic [1:0] REG_Y    = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    // address_i[1:0] offset of the collision register in the status region
    localparam logic [1:0] REG_COLLISION = 2'd0;

    // CTRL layout: bit0 enable, frame index starts at bit1
    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_FRAME_LSB = 1;

    localparam logic [23:0] DEFAULT_KEY_RGB = 24'hFF00FF;

    // Storage width for the frame index; a single-frame ROM still keeps one bit
    // (always zero) so the field never collapses to zero width.
    function automatic int unsigned frame_bits(input int unsigned frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/active position and CTRL registers with commit,
// hit test against the current pixel, ROM address generation and the S0 hit
// register.
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_x/y/ctrl_i    shadow register write strobes, wdata_i write data
//   commit_i         copy shadow (including a same-cycle write) into active
//   x_pos_i, y_pos_i current pixel coordinate (S0)
//   shadow_*_o       shadow values for bus readback
//   hit_q_o          registered hit flag, aligned with ROM data
//   mem_address_o    ROM address for this pixel, 0 when not hit
module sprite_channel import sprite_pkg::*; #(
    parameter int unsigned SPR_W   = 32,
    parameter int unsigned SPR_H   = 32,
    parameter int unsigned FRAMES  = 4,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned ROM_AW  = 12,
    parameter int unsigned FB      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_x_i,
    input  logic               wr_y_i,
    input  logic               wr_ctrl_i,
    input  logic [31:0]        wdata_i,
    input  logic               commit_i,
    input  logic [COORD_W-1:0] x_pos_i,
    input  logic [COORD_W-1:0] y_pos_i,
    output logic [COORD_W-1:0] shadow_x_o,
    output logic [COORD_W-1:0] shadow_y_o,
    output logic               shadow_en_o,
    output logic [FB-1:0]      shadow_frame_o,
    output logic               hit_q_o,
    output logic [ROM_AW-1:0]  mem_address_o
);

    localparam int unsigned XW = $clog2(SPR_W);
    localparam int unsigned YW = $clog2(SPR_H);
    localparam int unsigned CW = COORD_W + 1;
    localparam logic [FB-1:0] FRAME_MASK = FB'(FRAMES - 1);

    logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, ax_q, ay_q;
    logic               sen_q, sen_d, aen_q;
    logic [FB-1:0]      sfr_q, sfr_d, afr_q;
    logic [CW-1:0]      px, py, ax, ay, dx, dy;
    logic               hit;
    logic               unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        sx_d  = sx_q;
        sy_d  = sy_q;
        sen_d = sen_q;
        sfr_d = sfr_q;
        if (wr_x_i) sx_d = wdata_i[COORD_W-1:0];
        if (wr_y_i) sy_d = wdata_i[COORD_W-1:0];
        if (wr_ctrl_i) begin
            sen_d = wdata_i[CTRL_EN_BIT];
            sfr_d = wdata_i[CTRL_FRAME_LSB +: FB] & FRAME_MASK;
        end
    end

    // One extra bit so X+SPR_W never wraps: sprites clip at the right/bottom edge.
    assign px = {1'b0, x_pos_i};
    assign py = {1'b0, y_pos_i};
    assign ax = {1'b0, ax_q};
    assign ay = {1'b0, ay_q};
    assign dx = px - ax;
    assign dy = py - ay;

    assign hit = aen_q && (px >= ax) && (px < ax + CW'(SPR_W))
                       && (py >= ay) && (py < ay + CW'(SPR_H));

    // {frame, y offset, x offset}; offsets are below SPR_W/SPR_H whenever hit.
    assign mem_address_o = hit ? ((ROM_AW'(afr_q) << (XW + YW)) |
                                  (ROM_AW'(dy) << XW) | ROM_AW'(dx))
                               : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q    <= '0;
            sy_q    <= '0;
            sen_q   <= 1'b0;
            sfr_q   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            aen_q   <= 1'b0;
            afr_q   <= '0;
            hit_q_o <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sen_q   <= sen_d;
            sfr_q   <= sfr_d;
            hit_q_o <= hit;
            if (commit_i) begin
                ax_q  <= sx_d;
                ay_q  <= sy_d;
                aen_q <= sen_d;
                afr_q <= sfr_d;
            end
        end
    end

    assign shadow_x_o     = sx_q;
    assign shadow_y_o     = sy_q;
    assign shadow_en_o    = sen_q;
    assign shadow_frame_o = sfr_q;

endmodule

// File: rtl/sprite_engine.sv
// Multi-channel sprite engine: bus register decode and readback, N sprite
// channels, fixed-priority compositor with colour-key transparency and sticky
// write-1-to-clear collision flags. Two-stage pipeline (S0 hit/address, S1
// compose), one pixel per cycle.
//   clk, rst_n                 clock, asynchronous active-low reset
//   MW_i, address_i, data_i    bus write port; data_o registered read data
//   frame_start_i              commits all shadow registers
//   pixel_valid_i, x/y_pos_i, bg_rgb_i   pixel stream in
//   mem_address_o, mem_data_i  per-channel ROM port (1-cycle read latency)
//   RGB_o, RGB_valid_o         composed pixel out, 2 cycles after input
module sprite_engine import sprite_pkg::*; #(
    parameter int unsigned N_SPRITES = 4,
    parameter int unsigned SPR_W     = 32,
    parameter int unsigned SPR_H     = 32,
    parameter int unsigned FRAMES    = 4,
    parameter int unsigned COORD_W   = 10,
    parameter logic [23:0] KEY_RGB   = DEFAULT_KEY_RGB,
    localparam int unsigned ROM_AW   = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               MW_i,
    input  logic [9:0]                         address_i,
    input  logic [31:0]                        data_i,
    output logic [31:0]                        data_o,
    input  logic                               frame_start_i,
    input  logic                               pixel_valid_i,
    input  logic [COORD_W-1:0]                 x_pos_i,
    input  logic [COORD_W-1:0]                 y_pos_i,
    input  logic [23:0]                        bg_rgb_i,
    output logic [N_SPRITES-1:0][ROM_AW-1:0]   mem_address_o,
    input  logic [N_SPRITES-1:0][23:0]         mem_data_i,
    output logic [23:0]                        RGB_o,
    output logic                               RGB_valid_o
);

    localparam int unsigned FB = frame_bits(FRAMES);

    logic [1:0] region, rsel;
    logic [5:0] ch;
    logic       sprite_wr, coll_clr;

    logic [N_SPRITES-1:0] wr_x, wr_y, wr_ctrl, hit_s0, shadow_en;
    logic [COORD_W-1:0]   shadow_x [N_SPRITES];
    logic [COORD_W-1:0]   shadow_y [N_SPRITES];
    logic [FB-1:0]        shadow_frame [N_SPRITES];

    logic                 valid_q;
    logic [23:0]          bg_q, rgb_d;
    logic [N_SPRITES-1:0] opaque, coll_q, coll_d;
    logic                 multi;
    logic [31:0]          rdata;

    assign region    = address_i[9:8];
    assign ch        = address_i[7:2];
    assign rsel      = address_i[1:0];
    assign sprite_wr = MW_i && (region == REGION_SPRITE);
    assign coll_clr  = MW_i && (region == REGION_STATUS) && (rsel == REG_COLLISION);

    for (genvar i = 0; i < int'(N_SPRITES); i++) begin : g_ch
        logic sel;
        assign sel        = sprite_wr && (ch == 6'(i));
        assign wr_x[i]    = sel && (rsel == REG_X);
        assign wr_y[i]    = sel && (rsel == REG_Y);
        assign wr_ctrl[i] = sel && (rsel == REG_CTRL);

        sprite_channel #(
            .SPR_W   (SPR_W),
            .SPR_H   (SPR_H),
            .FRAMES  (FRAMES),
            .COORD_W (COORD_W),
            .ROM_AW  (ROM_AW),
            .FB      (FB)
        ) u_channel (
            .clk            (clk),
            .rst_n          (rst_n),
            .wr_x_i         (wr_x[i]),
            .wr_y_i         (wr_y[i]),
            .wr_ctrl_i      (wr_ctrl[i]),
            .wdata_i        (data_i),
            .commit_i       (frame_start_i),
            .x_pos_i        (x_pos_i),
            .y_pos_i        (y_pos_i),
            .shadow_x_o     (shadow_x[i]),
            .shadow_y_o     (shadow_y[i]),
            .shadow_en_o    (shadow_en[i]),
            .shadow_frame_o (shadow_frame[i]),
            .hit_q_o        (hit_s0[i]),
            .mem_address_o  (mem_address_o[i])
        );
    end

    // Read mux; unmapped channels, the reserved register and other regions read 0.
    always_comb begin
        rdata = '0;
        if (region == REGION_SPRITE) begin
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                if (ch == 6'(i)) begin
                    case (rsel)
                        REG_X:    rdata = 32'(shadow_x[i]);
                        REG_Y:    rdata = 32'(shadow_y[i]);
                        REG_CTRL: rdata = 32'({shadow_frame[i], shadow_en[i]});
                        default:  rdata = '0;
                    endcase
                end
            end
        end else if (region == REGION_STATUS && rsel == REG_COLLISION) begin
            rdata = 32'(coll_q);
        end
    end

    // S1: ascending scan so the highest-index opaque channel ends up on top.
    always_comb begin
        rgb_d  = bg_q;
        opaque = '0;
        for (int unsigned i = 0; i < N_SPRITES; i++) begin
            if (hit_s0[i] && (mem_data_i[i] != KEY_RGB)) begin
                opaque[i] = 1'b1;
                rgb_d     = mem_data_i[i];
            end
        end
        // Two or more bits set iff clearing the lowest set bit leaves something.
        multi  = (opaque & (opaque - N_SPRITES'(1))) != '0;
        coll_d = coll_q;
        if (coll_clr) coll_d = coll_d & ~N_SPRITES'(data_i);
        if (valid_q && multi) coll_d = coll_d | opaque;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            bg_q        <= '0;
            RGB_o       <= '0;
            RGB_valid_o <= 1'b0;
            coll_q      <= '0;
            data_o      <= '0;
        end else begin
            valid_q     <= pixel_valid_i;
            bg_q        <= bg_rgb_i;
            RGB_o       <= rgb_d;
            RGB_valid_o <= valid_q;
            coll_q      <= coll_d;
            data_o      <= rdata;
        end
    end

endmodule
